ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage consumer of the ID/EX register bundle for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Accepts a valid ID/EX M-op, runs a 32-iteration shift-add / restoring-divide engine, and holds o_stall
//  high so the front end freezes. Returns the result with o_valid for EX/MEM. Non-M ops pass untouched (never accepted).
// PARAMETERS
//  OP_BASE   5'd20  ALUOp code of MUL; MULH..REMU = OP_BASE+1..OP_BASE+7 in the order listed above
//  XLEN      32     operand/result width (only 32 supported)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   synchronous, active-low reset
//  i_valid   in   1   ID/EX slot valid
//  i_ALUOp   in   5   ID/EX ALU opcode
//  i_RD1     in   32  rs1 operand (dividend / multiplicand)
//  i_RD2     in   32  rs2 operand (divisor / multiplier)
//  i_rd      in   5   destination register
//  flush     in   1   kill in-flight op (branch/exception)
//  o_stall   out  1   freeze PC, IF/ID and ID/EX while op is pending
//  o_valid   out  1   one-cycle result strobe
//  o_result  out  32  result, held until next completion
//  o_rd      out  5   destination of o_result
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, count 0, o_valid 0, o_result 0, o_rd 0; o_stall 0.
//  - accept = (state==IDLE) & i_valid & (OP_BASE <= i_ALUOp <= OP_BASE+7) & ~flush.
//  - FSM IDLE->RUN on accept: latch op, rd, |RD1|, |RD2| (abs only for signed operands), sign flags, count=0.
//  - RUN: one iteration per cycle; count 0..31; RUN->DONE when count==31 (5-bit, no wrap past 31).
//  - DONE: o_valid=1 for exactly one cycle, o_result/o_rd registered; DONE->IDLE unconditionally.
//  - Latency: accept in cycle N -> o_valid high in cycle N+33. Back-to-back: next accept earliest in N+34.
//  - o_stall (combinational) = accept | (state==RUN). Low in DONE so the held instruction advances exactly once.
//  - MUL: low 32 of product; MULH/MULHSU/MULHU: high 32 of 64-bit product; product negated when result sign=1.
//  - DIV/REM via unsigned restoring division of magnitudes; quotient sign = sA^sB, remainder sign = sA.
//  - Divide by zero: quotient 0xFFFFFFFF (quotient sign fix suppressed), remainder = original RD1.
//  - Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0 (falls out of magnitude path).
//  - flush: in RUN or DONE -> IDLE next edge, count cleared; o_valid masked to 0 in a DONE cycle with flush=1.
//    flush in IDLE blocks accept. o_result/o_rd keep previous values on abort.
//  - reset mid-operation: abort silently, no o_valid, all outputs to reset values.
//  - i_* changes while RUN are ignored (operands latched at accept).
// CONFIGURATION
//  MULDIV_DIVZERO_FAST_EN defined: DIV/DIVU/REM/REMU with RD2==0 go IDLE->DONE directly (o_valid in N+1,
//    o_stall high only in accept cycle); results identical to the full path.
//  Not defined: divide-by-zero runs full 32 iterations, latency N+33.
// TESTING
//  MUL 7 x -3 (0x7, 0xFFFFFFFD) -> o_valid at N+33, o_result 0xFFFFFFEB, o_stall high N..N+32.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  DIVU 5/0 -> 0xFFFFFFFF, REM -5/0 -> 0xFFFFFFFB; with MULDIV_DIVZERO_FAST_EN o_valid at N+1, else N+33.
//  Start DIV, assert flush at N+10 -> IDLE at N+11, o_stall 0, no o_valid; later MUL 3x4 -> 12 at its N+33.
//  reset low at N+5 of a MULHSU -> o_valid/o_result/o_rd 0, o_stall 0; non-M ALUOp with i_valid -> no stall.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// It multiplies or divides the operand magnitudes over 32 cycles, then fixes the result sign.
// Optional feature macro: MULDIV_DIVZERO_FAST_EN. When it is defined, a divide by zero
// finishes directly from IDLE with a one-cycle latency.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   i_valid, i_ALUOp ID/EX slot valid and ALU opcode
//   i_RD1, i_RD2     rs1 / rs2 operands
//   i_rd             destination register
//   flush            kills the in-flight op
//   o_stall          combinational freeze request to the front end
//   o_valid          combinational one-cycle result strobe (masked by flush)
//   o_result, o_rd   registered result and destination, held until the next completion
module ex_muldiv_unit #(
   parameter logic [4:0]  OP_BASE = 5'd20,
   parameter int unsigned XLEN    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_valid,
   input  logic [4:0]      i_ALUOp,
   input  logic [XLEN-1:0] i_RD1,
   input  logic [XLEN-1:0] i_RD2,
   input  logic [4:0]      i_rd,
   input  logic            flush,
   output logic            o_stall,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd
);
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_d;
   logic [CW-1:0]     count;
   logic [2:0]        op_q;
   logic              sa_q, sb_q, bz_q;
   logic [XLEN-1:0]   hi_q, lo_q, b_q;
   logic [4:0]        rd_q;

   // Decode of the ID/EX slot
   logic [5:0]        op_lo;
   logic              in_range, in_div, in_sa, in_sb, neg_a, neg_b, in_bz, fast, accept;
   logic [2:0]        in_op;
   logic [XLEN-1:0]   mag_a, mag_b;

   assign op_lo    = {1'b0, OP_BASE};
   assign in_range = ({1'b0, i_ALUOp} >= op_lo) && ({1'b0, i_ALUOp} <= 6'(op_lo + 6'd7));
   assign in_op    = 3'(i_ALUOp - OP_BASE);
   assign in_div   = in_op[2];
   // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 is signed for the same set except MULHSU
   assign in_sa    = (in_op != 3'd3) && (in_op != 3'd5) && (in_op != 3'd7);
   assign in_sb    = in_sa && (in_op != 3'd2);
   assign neg_a    = in_sa & i_RD1[XLEN-1];
   assign neg_b    = in_sb & i_RD2[XLEN-1];
   assign mag_a    = neg_a ? -i_RD1 : i_RD1;
   assign mag_b    = neg_b ? -i_RD2 : i_RD2;
   assign in_bz    = (i_RD2 == '0);
`ifdef MULDIV_DIVZERO_FAST_EN
   assign fast     = in_div & in_bz;
`else
   assign fast     = 1'b0;
`endif
   assign accept   = (state == IDLE) & i_valid & in_range & ~flush;

   // One iteration step: shift-add multiply (product in hi:lo) or restoring divide (rem:quo in hi:lo)
   logic [XLEN:0]     mul_sum, div_rs, div_sub;
   logic              div_ge;
   logic [XLEN-1:0]   hi_n, lo_n, quo, rem, res;
   logic [2*XLEN-1:0] prod, prod_s;

   always_comb begin
      mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
      div_rs  = {hi_q, lo_q[XLEN-1]};
      div_ge  = div_rs >= {1'b0, b_q};
      div_sub = div_rs - {1'b0, b_q};
      if (op_q[2]) begin
         hi_n = div_ge ? div_sub[XLEN-1:0] : div_rs[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], div_ge};
      end else begin
         hi_n = mul_sum[XLEN:1];
         lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign fix-up of the final iteration; quotient keeps all-ones on divide by zero
   always_comb begin
      prod   = {hi_n, lo_n};
      prod_s = (sa_q ^ sb_q) ? -prod : prod;
      quo    = ((sa_q ^ sb_q) && !bz_q) ? -lo_n : lo_n;
      rem    = sa_q ? -hi_n : hi_n;
      case (op_q)
         3'd0:       res = prod_s[XLEN-1:0];
         3'd4, 3'd5: res = quo;
         3'd6, 3'd7: res = rem;
         default:    res = prod_s[2*XLEN-1:XLEN];
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // FSM next state and combinational handshake outputs
   always_comb begin
      state_d = state;
      o_stall = accept | (state == RUN);
      o_valid = (state == DONE) & ~flush;
      case (state)
         IDLE:    if (accept) state_d = fast ? DONE : RUN;
         RUN:     if (flush) state_d = IDLE;
                  else if (count == CW'(31)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand latch, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         count    <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         o_result <= '0;
         o_rd     <= '0;
      end else if (accept) begin
         count <= '0;
         op_q  <= in_op;
         rd_q  <= i_rd;
         sa_q  <= neg_a;
         sb_q  <= neg_b;
         bz_q  <= in_bz;
         hi_q  <= '0;
         lo_q  <= in_div ? mag_a : mag_b;
         b_q   <= in_div ? mag_b : mag_a;
         if (fast) begin
            o_result <= in_op[1] ? i_RD1 : {XLEN{1'b1}};
            o_rd     <= i_rd;
         end
      end else if (state == RUN && !flush) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
         if (count == CW'(31)) begin
            count    <= '0;
            o_result <= res;
            o_rd     <= rd_q;
         end else begin
            count <= count + CW'(1);
         end
      end else begin
         count <= '0;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed bench for ex_muldiv_unit with an expected-result scoreboard.
// Expected results come from a 64-bit arithmetic reference model plus a latency table.
module tb_ex_muldiv_unit;
   localparam logic [4:0] OPB = 5'd20;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [4:0]  i_ALUOp;
   logic [31:0] i_RD1, i_RD2;
   logic [4:0]  i_rd;
   logic        flush;
   logic        o_stall, o_valid;
   logic [31:0] o_result;
   logic [4:0]  o_rd;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   ex_muldiv_unit #(.OP_BASE(OPB), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_ALUOp(i_ALUOp),
      .i_RD1(i_RD1), .i_RD2(i_RD2), .i_rd(i_rd), .flush(flush),
      .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: sign/zero-extended 64-bit product, native SV division for the divide ops
   function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 3 || op == 5 || op == 7) ? {32'h0, a} : {{32{a[31]}}, a};
      eb = (op == 2 || op == 3) ? {32'h0, b} : {{32{b[31]}}, b};
      if (op < 4) begin
         p = ea * eb;
         return (op == 0) ? p[31:0] : p[63:32];
      end
      if (b == 32'h0) return (op >= 6) ? a : 32'hFFFF_FFFF;
      if (op == 5) return a / b;
      if (op == 7) return a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 4) ? a : 32'h0;
      if (op == 4) return 32'($signed(a) / $signed(b));
      return 32'($signed(a) % $signed(b));
   endfunction

   task automatic no_valid(input int n, input string tag);
      bit bad = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (o_valid) bad = 1'b1;
      end
      check(tag, 32'(bad), 32'h0);
   endtask

   // Issue one op; while it runs, the ID/EX inputs carry unrelated M-ops that must be ignored.
   // flush_at > 0 asserts flush in that cycle after accept instead of expecting a result.
   task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int flush_at);
      exp_t e, got;
      int   lat;
      bit   seen;
      @(negedge clk);
      i_valid = 1'b1;
      i_ALUOp = OPB + 5'(op);
      i_RD1   = a;
      i_RD2   = b;
      i_rd    = rd;
      #1 check("stall_accept", 32'(o_stall), 32'h1);
      e.res = model(op, a, b);
      e.rd  = rd;
      e.lat = 33;
`ifdef MULDIV_DIVZERO_FAST_EN
      if (op >= 4 && b == 32'h0) e.lat = 1;
`endif
      if (flush_at == 0) sb_q.push_back(e);
      seen = 1'b0;
      lat  = 1;
      while (lat <= 60 && !seen) begin
         @(negedge clk);
         if (flush_at != 0 && lat == flush_at) begin
            flush   = 1'b1;
            i_valid = 1'b0;
            #1 check("valid_masked_by_flush", 32'(o_valid), 32'h0);
            @(negedge clk);
            flush = 1'b0;
            check("stall_after_flush", 32'(o_stall), 32'h0);
            check("valid_after_flush", 32'(o_valid), 32'h0);
            seen = 1'b1;
         end else if (o_valid) begin
            i_valid = 1'b0;
            seen    = 1'b1;
            check("stall_done", 32'(o_stall), 32'h0);
            if (sb_q.size() == 0) begin
               check("unexpected_valid", 32'h1, 32'h0);
            end else begin
               got = sb_q.pop_front();
               check("result", o_result, got.res);
               check("rd", 32'(o_rd), 32'(got.rd));
               check("latency", 32'(lat), 32'(got.lat));
            end
         end else begin
            if (lat < e.lat) check("stall_run", 32'(o_stall), 32'h1);
            i_ALUOp = OPB + 5'($urandom_range(0, 7));
            i_RD1   = $urandom;
            i_RD2   = $urandom;
            i_rd    = 5'($urandom);
         end
         lat++;
      end
      i_valid = 1'b0;
      if (!seen) check("timeout_no_valid", 32'h0, 32'h1);
      if (flush_at != 0) no_valid(40, "no_valid_after_flush");
   endtask

   task automatic non_m(input logic [4:0] opc);
      @(negedge clk);
      i_valid = 1'b1;
      i_ALUOp = opc;
      i_RD1   = 32'h1234;
      i_RD2   = 32'h5;
      #1 check("non_m_stall", 32'(o_stall), 32'h0);
      no_valid(40, "non_m_no_valid");
      i_valid = 1'b0;
   endtask

   initial begin
      int op;
      reset   = 1'b0;
      i_valid = 1'b0;
      i_ALUOp = '0;
      i_RD1   = '0;
      i_RD2   = '0;
      i_rd    = '0;
      flush   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_stall", 32'(o_stall), 32'h0);
      check("rst_result", o_result, 32'h0);
      check("rst_rd", 32'(o_rd), 32'h0);
      reset = 1'b1;

      run_op(0, 32'h7, 32'hFFFF_FFFD, 5'd1, 0);
      run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
      run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
      run_op(4, 32'hFFFF_FFF9, 32'h2, 5'd4, 0);
      run_op(6, 32'hFFFF_FFF9, 32'h2, 5'd5, 0);
      run_op(4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
      run_op(6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
      run_op(5, 32'h5, 32'h0, 5'd8, 0);
      run_op(6, 32'hFFFF_FFFB, 32'h0, 5'd9, 0);
      run_op(4, 32'hFFFF_FFFB, 32'h0, 5'd10, 0);
      run_op(2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd11, 0);
      for (int i = 0; i < 8; i++) begin
         op = i;
         run_op(op, $urandom, $urandom, 5'(12 + i), 0);
      end

      // flush while RUN, then a clean op; flush during DONE masks the strobe
      run_op(4, 32'd100, 32'd7, 5'd20, 10);
      run_op(0, 32'd3, 32'd4, 5'd21, 0);
      run_op(0, 32'd9, 32'd9, 5'd22, 33);

      // opcodes just outside the M range, and an ordinary ALU op
      non_m(OPB - 5'd1);
      non_m(OPB + 5'd8);
      non_m(5'd5);

      // reset in the middle of a MULHSU
      @(negedge clk);
      i_valid = 1'b1;
      i_ALUOp = OPB + 5'd2;
      i_RD1   = 32'hFFFF_0000;
      i_RD2   = 32'h0001_0003;
      i_rd    = 5'd30;
      repeat (5) @(negedge clk);
      i_valid = 1'b0;
      reset   = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(o_valid), 32'h0);
      check("midrst_stall", 32'(o_stall), 32'h0);
      check("midrst_result", o_result, 32'h0);
      check("midrst_rd", 32'(o_rd), 32'h0);
      reset = 1'b1;
      no_valid(40, "midrst_no_valid");

      check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
